serial_encoder: RTL and testbench

//  Parallel-in/serial-out (PISO) transmit stage, directly upstream of the SIPO receive stage.

---
 rtl/serial_encoder.sv | 116 +++++++++++
 tb/tb_serial_encoder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/serial_encoder.sv
// PISO transmit stage: a small input FIFO feeds a shifter that sends words LSB first with no gaps
// between queued words, and flags bit 0 of every frame on frameStart.
//
// state | meaning
// IDLE  | line quiet (serialOut=0), waiting for a buffered word
// SHIFT | a word is on the line; bit_cnt is the index of the bit currently driven
module serial_encoder #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             parallelIn,
    input  logic                              inValid,
    output logic                              inReady,
    output logic                              serialOut,
    output logic                              frameStart,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH):0]       fifoCount
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BC_W-1:0]       bit_cnt, bit_cnt_nxt;
    logic                  push, pop;
    logic                  serial_nxt, frame_nxt, busy_nxt;
    logic [DATA_WIDTH-1:0] head;

    // Readiness depends on occupancy only, so a full FIFO stalls input even while popping.
    assign inReady   = (count != FULL);
    assign push      = inValid && inReady;
    assign head      = fifo_mem[rd_ptr];
    assign fifoCount = count;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        serial_nxt  = 1'b0;
        frame_nxt   = 1'b0;
        busy_nxt    = 1'b0;
        bit_cnt_nxt = bit_cnt;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop         = 1'b1;
                    serial_nxt  = head[0];
                    frame_nxt   = 1'b1;
                    busy_nxt    = 1'b1;
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt != LAST_BIT) begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    serial_nxt  = shift_reg[bit_cnt_nxt];
                    busy_nxt    = 1'b1;
                end else if (count != '0) begin
                    pop         = 1'b1;
                    serial_nxt  = head[0];
                    frame_nxt   = 1'b1;
                    busy_nxt    = 1'b1;
                    bit_cnt_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= parallelIn;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            serialOut  <= 1'b0;
            frameStart <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) shift_reg <= head;
            bit_cnt    <= bit_cnt_nxt;
            serialOut  <= serial_nxt;
            frameStart <= frame_nxt;
            busy       <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_serial_encoder.sv
// Bench for serial_encoder: a word-level reference model (FIFO queue plus current word/bit position)
// predicts every output each cycle, and an emulated SIPO receiver checks in-order word reconstruction.
module tb_serial_encoder;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] parallelIn;
    logic       inValid;
    logic       inReady;
    logic       serialOut;
    logic       frameStart;
    logic       busy;
    logic [2:0] fifoCount;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic [7:0] sent[$];
    logic [7:0] cur_word;
    int         pos = -1;
    logic [7:0] rx_word;
    int         rx_n = 0;
    bit         primed = 0;

    serial_encoder #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .parallelIn(parallelIn), .inValid(inValid),
        .inReady(inReady), .serialOut(serialOut), .frameStart(frameStart),
        .busy(busy), .fifoCount(fifoCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic rst, input logic v, input logic [7:0] d);
        logic acc;
        reset = rst; inValid = v; parallelIn = d;
        @(negedge clock);
        if (primed) chk("inReady", inReady, 32'(mq.size() < 4));
        acc = v && (mq.size() < 4) && !rst;
        @(posedge clock);
        if (rst) begin
            mq.delete(); sent.delete(); pos = -1; rx_n = 0;
        end else begin
            if ((pos < 0 || pos == 7) && mq.size() > 0) begin
                cur_word = mq.pop_front(); pos = 0;
            end else if (pos >= 0 && pos < 7) begin
                pos++;
            end else begin
                pos = -1;
            end
            if (acc) begin mq.push_back(d); sent.push_back(d); end
        end
        #1;
        primed = 1;
        chk("serialOut",  serialOut,  32'((pos >= 0) ? cur_word[pos] : 1'b0));
        chk("frameStart", frameStart, 32'(pos == 0));
        chk("busy",       busy,       32'(pos >= 0));
        chk("fifoCount",  fifoCount,  32'(mq.size()));
        // SIPO receiver driven purely by the line signals
        if (!rst && busy) begin
            if (frameStart) begin
                chk("rx_align", rx_n, 0);
                rx_n = 0;
            end
            rx_word[rx_n] = serialOut;
            rx_n++;
            if (rx_n == 8) begin
                chk("rx_avail", 32'(sent.size() != 0), 1);
                if (sent.size() != 0) chk("rx_word", rx_word, sent.pop_front());
                rx_n = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        reset = 1'b1; inValid = 1'b0; parallelIn = '0;

        // power-on reset
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        chk("reset_inReady", inReady, 1);

        // single word 0xA5
        tick(1'b0, 1'b1, 8'hA5);
        idle(12);

        // back-to-back words
        tick(1'b0, 1'b1, 8'h01);
        tick(1'b0, 1'b1, 8'h80);
        tick(1'b0, 1'b1, 8'hFF);
        tick(1'b0, 1'b1, 8'h00);
        idle(36);

        // hold inValid with incrementing data: backpressure at full
        for (int i = 0; i < 24; i++) tick(1'b0, 1'b1, 8'(8'h10 + i));
        chk("full_count", fifoCount, mq.size());
        idle(50);

        // push coinciding with a frame-boundary pop at fifoCount=2
        tick(1'b0, 1'b1, 8'h3C);
        tick(1'b0, 1'b1, 8'h5A);
        tick(1'b0, 1'b1, 8'hC3);
        idle(6);
        chk("pre_boundary_count", fifoCount, 2);
        tick(1'b0, 1'b1, 8'h99);
        chk("boundary_count", fifoCount, 2);
        idle(40);

        // reset mid-frame aborts the frame and flushes the FIFO
        tick(1'b0, 1'b1, 8'hE7);
        tick(1'b0, 1'b1, 8'h18);
        tick(1'b0, 1'b1, 8'h6B);
        idle(3);
        tick(1'b1, 1'b1, 8'h77);
        tick(1'b1, 1'b0, 8'h00);
        chk("rst_serialOut", serialOut, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifoCount, 0);
        idle(12);

        // random traffic through the SIPO loopback
        for (int i = 0; i < 400; i++)
            tick(1'b0, 1'($urandom_range(0, 99) < 30), 8'($urandom));
        idle(50);
        chk("rx_drained", 32'(sent.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
